// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU/mul/div control sequencer: state encoding,
// instruction field layout, opcode and ALU operation codes.
package alu_seq_pkg;

    localparam int unsigned OPW  = 5;          // opcode field width
    localparam int unsigned RW   = 4;          // register-select field width
    localparam int unsigned NREG = 1 << RW;    // register file entries
    localparam int unsigned IRW  = 32;         // instruction register width
    localparam int unsigned ALUW = 4;          // ALU operation select width

    // Instruction field positions (LSB of each field)
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_LSB = 15;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALT
    } state_t;

    // Opcodes
    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPW-1:0] OP_AND  = 5'b00010;
    localparam logic [OPW-1:0] OP_OR   = 5'b00011;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00101;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00110;
    localparam logic [OPW-1:0] OP_ROL  = 5'b00111;
    localparam logic [OPW-1:0] OP_NEG  = 5'b01000;
    localparam logic [OPW-1:0] OP_NOT  = 5'b01001;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    // ALU operation select codes
    localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
    localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
    localparam logic [ALUW-1:0] ALU_AND = 4'd2;
    localparam logic [ALUW-1:0] ALU_OR  = 4'd3;
    localparam logic [ALUW-1:0] ALU_SHR = 4'd4;
    localparam logic [ALUW-1:0] ALU_SHL = 4'd5;
    localparam logic [ALUW-1:0] ALU_ROR = 4'd6;
    localparam logic [ALUW-1:0] ALU_ROL = 4'd7;
    localparam logic [ALUW-1:0] ALU_NEG = 4'd8;
    localparam logic [ALUW-1:0] ALU_NOT = 4'd9;

    // Single-cycle ALU instructions occupy the contiguous opcode range add..not
    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return (op <= OP_NOT);
    endfunction

    function automatic logic [ALUW-1:0] alu_code(input logic [OPW-1:0] op);
        logic [ALUW-1:0] code;
        case (op)
            OP_ADD:  code = ALU_ADD;
            OP_SUB:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_OR:   code = ALU_OR;
            OP_SHR:  code = ALU_SHR;
            OP_SHL:  code = ALU_SHL;
            OP_ROR:  code = ALU_ROR;
            OP_ROL:  code = ALU_ROL;
            OP_NEG:  code = ALU_NEG;
            OP_NOT:  code = ALU_NOT;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// One-hot register select decoder with enable.
//   en     : when low the output is all zero
//   sel    : register index
//   onehot : single bit set at position sel when enabled
import alu_seq_pkg::*;

module reg_onehot_dec (
    input  logic            en,
    input  logic [RW-1:0]   sel,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = NREG'(1) << sel;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Hardwired control unit: fetches an instruction and steps the datapath
// through register-register ALU, mul and div execution.
//   clock, clear        : rising-edge clock, asynchronous active-high reset
//   run                 : fetch enable, sampled in IDLE and at instruction end
//   ir_q, mem_ready     : IR contents and memory read-data-valid handshake
//   Rin, Rout           : one-hot register load / bus drive
//   PC/MAR/MDR/IR/Y/Z/HI/LO strobes, ALUop, ALU_MUL, ALU_DIV : datapath control
//   halted, busy        : run status
// Outputs are Moore decodes of the state and IR fields.
import alu_seq_pkg::*;

module alu_sequencer (
    input  logic            clock,
    input  logic            clear,
    input  logic            run,
    input  logic [IRW-1:0]  ir_q,
    input  logic            mem_ready,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            PCin,
    output logic            PCout,
    output logic            IncPC,
    output logic            MARin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zlowin,
    output logic            Zhighin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIin,
    output logic            LOin,
    output logic [ALUW-1:0] ALUop,
    output logic            ALU_MUL,
    output logic            ALU_DIV,
    output logic            halted,
    output logic            busy
);

    state_t          state;
    logic            t1_seen;   // set after the first T1 cycle so PCin fires once

    logic [OPW-1:0]  op;
    logic [RW-1:0]   ra;
    logic [RW-1:0]   rb;
    logic [RW-1:0]   rc;
    logic            op_alu;
    logic            op_mul;
    logic            op_div;
    logic            op_exec;

    logic            rin_en;
    logic [RW-1:0]   rin_sel;
    logic            rout_en;
    logic [RW-1:0]   rout_sel;

    logic            unused_ir_bits;

    assign op      = ir_q[OP_LSB +: OPW];
    assign ra      = ir_q[RA_LSB +: RW];
    assign rb      = ir_q[RB_LSB +: RW];
    assign rc      = ir_q[RC_LSB +: RW];
    assign op_alu  = is_alu_op(op);
    assign op_mul  = (op == OP_MUL);
    assign op_div  = (op == OP_DIV);
    assign op_exec = op_alu | op_mul | op_div;

    assign unused_ir_bits = ^ir_q[RC_LSB-1:0];

    // State sequencing; run is consulted only in IDLE and at instruction end
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            t1_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= T0;
                    end
                end
                T0: begin
                    state   <= T1;
                    t1_seen <= 1'b0;
                end
                T1: begin
                    t1_seen <= 1'b1;
                    if (mem_ready) begin
                        state <= T2;
                    end
                end
                T2: state <= T3;
                T3: begin
                    case (op)
                        OP_HALT: state <= HALT;
                        OP_NOP:  state <= run ? T0 : IDLE;
                        default: begin
                            if (op_exec) begin
                                state <= T4;
                            end else begin
                                state <= run ? T0 : IDLE;
                            end
                        end
                    endcase
                end
                T4: state <= T5;
                T5: begin
                    if (op_alu) begin
                        state <= run ? T0 : IDLE;
                    end else begin
                        state <= T6;
                    end
                end
                T6:      state <= run ? T0 : IDLE;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Control strobe decode
    always_comb begin
        rin_en   = 1'b0;
        rin_sel  = '0;
        rout_en  = 1'b0;
        rout_sel = '0;
        PCin     = 1'b0;
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ALUop    = '0;
        ALU_MUL  = 1'b0;
        ALU_DIV  = 1'b0;
        halted   = (state == HALT);
        busy     = (state != IDLE) && (state != HALT);

        case (state)
            T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = ~t1_seen;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (op_exec) begin
                    rout_en  = 1'b1;
                    rout_sel = rb;
                    Yin      = 1'b1;
                end
            end
            T4: begin
                rout_en  = 1'b1;
                rout_sel = rc;
                Zlowin   = 1'b1;
                if (op_alu) begin
                    ALUop = alu_code(op);
                end else begin
                    ALU_MUL = op_mul;
                    ALU_DIV = op_div;
                    Zhighin = 1'b1;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (op_alu) begin
                    rin_en  = 1'b1;
                    rin_sel = ra;
                end else begin
                    LOin = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    reg_onehot_dec u_rin_dec (
        .en     (rin_en),
        .sel    (rin_sel),
        .onehot (Rin)
    );

    reg_onehot_dec u_rout_dec (
        .en     (rout_en),
        .sel    (rout_sel),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed instruction table,
// hand-written reset/halt/async-clear sequences and a randomized run
// compared cycle by cycle against a per-instruction control trace model.
module tb_alu_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic [31:0] ir_q;
    logic        mem_ready;
    logic [15:0] Rin, Rout;
    logic        PCin, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [3:0]  ALUop;
    logic        ALU_MUL, ALU_DIV, halted, busy;

    int checks = 0;
    int errors = 0;

    alu_sequencer dut (
        .clock    (clock),
        .clear    (clear),
        .run      (run),
        .ir_q     (ir_q),
        .mem_ready(mem_ready),
        .Rin      (Rin),
        .Rout     (Rout),
        .PCin     (PCin),
        .PCout    (PCout),
        .IncPC    (IncPC),
        .MARin    (MARin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zlowin   (Zlowin),
        .Zhighin  (Zhighin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .HIin     (HIin),
        .LOin     (LOin),
        .ALUop    (ALUop),
        .ALU_MUL  (ALU_MUL),
        .ALU_DIV  (ALU_DIV),
        .halted   (halted),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcin, pcout, incpc, marin, read, mdrin, mdrout, irin;
        logic yin, zlowin, zhighin, zlowout, zhighout, hiin, loin;
        logic [3:0] aluop;
        logic mul, div, halted, busy;
    } outs_t;

    typedef struct packed {
        logic  mr;
        outs_t o;
    } step_t;

    typedef struct {
        logic [31:0] ir;
        int          w;
        logic [15:0] rout3;
        logic        yin3;
        logic [15:0] rout4;
        logic [3:0]  alu4;
        logic        mul4;
        logic        div4;
        logic        zh4;
        logic [15:0] rin5;
        logic        lo5;
        logic        hi6;
        int          len;
    } vec_t;

    step_t exp_q[$];

    function automatic outs_t get_outs();
        outs_t o;
        o.rin = Rin; o.rout = Rout;
        o.pcin = PCin; o.pcout = PCout; o.incpc = IncPC; o.marin = MARin;
        o.read = Read; o.mdrin = MDRin; o.mdrout = MDRout; o.irin = IRin;
        o.yin = Yin; o.zlowin = Zlowin; o.zhighin = Zhighin; o.zlowout = Zlowout;
        o.zhighout = Zhighout; o.hiin = HIin; o.loin = LOin;
        o.aluop = ALUop; o.mul = ALU_MUL; o.div = ALU_DIV;
        o.halted = halted; o.busy = busy;
        return o;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    task automatic check_outs(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Bus exclusivity: at most one driver on the shared bus per cycle
    always @(negedge clock) begin
        if (!clear) begin
            int n;
            n = $countones(Rout) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
            checks++;
            assert (n <= 1) else begin
                errors++;
                $display("FAIL bus_exclusive drivers=%0d required<=1 at %0t", n, $time);
            end
        end
    end

    // Reference: the full expected control trace of one instruction from T0
    // onward, with the mem_ready value to drive in each of those cycles.
    task automatic push_step(input logic mr, input outs_t o);
        step_t s;
        s.mr = mr;
        s.o  = o;
        exp_q.push_back(s);
    endtask

    task automatic build_trace(input logic [4:0] op, input logic [3:0] ra,
                               input logic [3:0] rb, input logic [3:0] rc, input int w);
        outs_t o;
        int    kind;   // 0 ALU, 1 mul, 2 div, 3 no execution
        if (op <= 5'd9)       kind = 0;
        else if (op == 5'd15) kind = 1;
        else if (op == 5'd16) kind = 2;
        else                  kind = 3;

        o = '0; o.busy = 1'b1;
        o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zlowin = 1'b1;
        push_step(1'($urandom_range(0, 1)), o);
        for (int i = 0; i <= w; i++) begin
            o = '0; o.busy = 1'b1;
            o.zlowout = 1'b1; o.read = 1'b1; o.mdrin = 1'b1; o.pcin = (i == 0);
            push_step(i == w, o);
        end
        o = '0; o.busy = 1'b1; o.mdrout = 1'b1; o.irin = 1'b1;
        push_step(1'($urandom_range(0, 1)), o);
        o = '0; o.busy = 1'b1;
        if (kind != 3) begin
            o.rout = 16'(1) << rb;
            o.yin  = 1'b1;
        end
        push_step(1'($urandom_range(0, 1)), o);
        if (kind == 3) return;
        o = '0; o.busy = 1'b1; o.rout = 16'(1) << rc; o.zlowin = 1'b1;
        if (kind == 0) o.aluop = op[3:0];
        else begin
            o.mul = (kind == 1); o.div = (kind == 2); o.zhighin = 1'b1;
        end
        push_step(1'($urandom_range(0, 1)), o);
        o = '0; o.busy = 1'b1; o.zlowout = 1'b1;
        if (kind == 0) o.rin = 16'(1) << ra;
        else           o.loin = 1'b1;
        push_step(1'($urandom_range(0, 1)), o);
        if (kind != 0) begin
            o = '0; o.busy = 1'b1; o.zhighout = 1'b1; o.hiin = 1'b1;
            push_step(1'($urandom_range(0, 1)), o);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    vec_t  tbl[8];
    outs_t zero_o;
    outs_t halt_o;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_o = '0;
        halt_o = '0;
        halt_o.halted = 1'b1;

        //          ir                          w  rout3    y  rout4    alu  mul  div  zh   rin5     lo   hi  len
        tbl[0] = '{32'h81988000,               0, 16'h0008, 1, 16'h0002, 4'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 7};
        tbl[1] = '{32'h02920000,               3, 16'h0004, 1, 16'h0010, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b0, 9};
        tbl[2] = '{32'hF8000000,               0, 16'h0000, 0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4};
        tbl[3] = '{mk_ir(5'b01111, 7, 1, 2),   1, 16'h0002, 1, 16'h0004, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 8};
        tbl[4] = '{mk_ir(5'b01001, 0, 9, 3),   2, 16'h0200, 1, 16'h0008, 4'd9, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 8};
        tbl[5] = '{mk_ir(5'b00111, 15, 14, 13),0, 16'h4000, 1, 16'h2000, 4'd7, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 6};
        tbl[6] = '{mk_ir(5'b11010, 1, 2, 3),   1, 16'h0000, 0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5};
        tbl[7] = '{mk_ir(5'b00001, 2, 0, 15),  0, 16'h0001, 1, 16'h8000, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 6};

        clear = 1'b1; run = 1'b0; ir_q = '0; mem_ready = 1'b0;

        // Reset held, then idle with run low
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_outs("reset_hold", get_outs(), zero_o);
        @(posedge clock); #1;
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_outs($sformatf("idle_%0d", i), get_outs(), zero_o);
        end

        // Directed table, back to back with run held high
        do_clear();
        run = 1'b1; mem_ready = 1'b1; ir_q = tbl[0].ir;
        @(posedge clock); #1;
        @(negedge clock);
        check_int("table_first_t0", int'(PCout), 1);
        for (int v = 0; v < 8; v++) begin
            int k, len, pcin_n, read_n;
            logic [15:0] rout3, rout4, rin5;
            logic yin3, mul4, div4, zh4, lo5, hi6;
            logic [3:0] alu4;
            k = 0; len = 0; pcin_n = 0; read_n = 0;
            rout3 = '0; rout4 = '0; rin5 = '0; alu4 = '0;
            yin3 = 0; mul4 = 0; div4 = 0; zh4 = 0; lo5 = 0; hi6 = 0;
            ir_q = tbl[v].ir;
            while (len == 0) begin
                @(posedge clock); #1;
                k++;
                mem_ready = (k <= tbl[v].w) ? 1'b0 : 1'b1;
                @(negedge clock);
                if (PCout) len = k;
                else begin
                    pcin_n += int'(PCin);
                    read_n += int'(Read);
                    if (k == tbl[v].w + 3) begin rout3 = Rout; yin3 = Yin; end
                    if (k == tbl[v].w + 4) begin
                        rout4 = Rout; alu4 = ALUop; mul4 = ALU_MUL; div4 = ALU_DIV; zh4 = Zhighin;
                    end
                    if (k == tbl[v].w + 5) begin rin5 = Rin; lo5 = LOin; end
                    if (k == tbl[v].w + 6) hi6 = HIin;
                    if (k >= 30) len = k;
                end
            end
            check_int($sformatf("v%0d_len", v), len, tbl[v].len);
            check_int($sformatf("v%0d_pcin_count", v), pcin_n, 1);
            check_int($sformatf("v%0d_read_count", v), read_n, tbl[v].w + 1);
            check_int($sformatf("v%0d_t3_rout", v), int'(rout3), int'(tbl[v].rout3));
            check_int($sformatf("v%0d_t3_yin", v), int'(yin3), int'(tbl[v].yin3));
            check_int($sformatf("v%0d_t4_rout", v), int'(rout4), int'(tbl[v].rout4));
            check_int($sformatf("v%0d_t4_aluop", v), int'(alu4), int'(tbl[v].alu4));
            check_int($sformatf("v%0d_t4_mul", v), int'(mul4), int'(tbl[v].mul4));
            check_int($sformatf("v%0d_t4_div", v), int'(div4), int'(tbl[v].div4));
            check_int($sformatf("v%0d_t4_zhighin", v), int'(zh4), int'(tbl[v].zh4));
            check_int($sformatf("v%0d_t5_rin", v), int'(rin5), int'(tbl[v].rin5));
            check_int($sformatf("v%0d_t5_loin", v), int'(lo5), int'(tbl[v].lo5));
            check_int($sformatf("v%0d_t6_hiin", v), int'(hi6), int'(tbl[v].hi6));
        end

        // Halt: reached after T3, sticky while run is high, left only via clear
        do_clear();
        run = 1'b1; mem_ready = 1'b1; ir_q = 32'hD8000000;
        repeat (5) @(posedge clock);
        #1;
        @(negedge clock);
        check_outs("halt_entry", get_outs(), halt_o);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_outs($sformatf("halt_hold_%0d", i), get_outs(), halt_o);
        end
        #1 clear = 1'b1;
        #1 check_outs("halt_clear_async", get_outs(), zero_o);
        @(posedge clock); #1;
        run = 1'b0; clear = 1'b0;
        @(negedge clock);
        check_outs("halt_clear_idle", get_outs(), zero_o);

        // Async clear in the middle of T4 of an add
        run = 1'b1; ir_q = 32'h02920000; mem_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        @(negedge clock);
        check_int("async_t4_zlowin", int'(Zlowin), 1);
        check_int("async_t4_rout", int'(Rout), 16'h0010);
        #1 clear = 1'b1;
        #1 check_outs("async_clear_drop", get_outs(), zero_o);
        @(posedge clock); #1;
        clear = 1'b0;

        // Randomized instruction stream against the trace model
        do_clear();
        run = 1'b1;
        @(posedge clock); #1;
        for (int n = 0; n < 500; n++) begin
            logic [4:0] op;
            logic [3:0] ra, rb, rc;
            int w;
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
            w  = int'($urandom_range(0, 3));
            ir_q = mk_ir(op, ra, rb, rc);
            exp_q.delete();
            build_trace(op, ra, rb, rc, w);
            for (int s = 0; s < exp_q.size(); s++) begin
                mem_ready = exp_q[s].mr;
                @(negedge clock);
                check_outs($sformatf("rand_i%0d_op%0d_c%0d", n, op, s), get_outs(), exp_q[s].o);
                @(posedge clock); #1;
            end
        end
        run = 1'b0;
        repeat (10) @(posedge clock);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Hardwired control unit that sequences the existing datapath through fetch and execution of register-register ALU, mul and div instructions.
- Replaces the hand-written state/control process that benches currently drive directly.
- Sits beside the datapath:
  - drives every datapath control strobe;
  - observes the IR contents and a memory-ready handshake;
  - exposes run/halt status to the top level.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- RW, 4, register-select field width; register file has 2**RW = 16 entries.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- run  in  1  level; sequencer leaves IDLE and fetches while high.
- ir_q  in  32  current IR contents from the datapath.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- Rin  out  16  one-hot register load.
- Rout  out  16  one-hot register drive.
- PCin, PCout, IncPC, MARin  out  1 each  PC/MAR strobes.
- Read, MDRin, MDRout, IRin  out  1 each  memory/MDR/IR strobes.
- Yin, Zlowin, Zhighin, Zlowout, Zhighout  out  1 each  Y/Z strobes.
- HIin, LOin  out  1 each  HI/LO load.
- ALUop  out  4  ALU operation select.
- ALU_MUL, ALU_DIV  out  1 each  multiply/divide select.
- halted  out  1  high in HALT state.
- busy  out  1  high in any state except IDLE and HALT.

Behaviour:
- IR fields:
  - op = ir_q[31:27];
  - ra = ir_q[26:23] (destination);
  - rb = ir_q[22:19];
  - rc = ir_q[18:15].
- Rin/Rout are the one-hot decode of the selected field: exactly one bit set when asserted, otherwise all zero.
- State register is updated on the rising edge of clock. All outputs are combinational decodes of state and ir_q (Moore; no output depends on mem_ready).
- clear forces state to IDLE immediately, including mid-instruction. All outputs are 0 while clear is high and in IDLE.
- State sequence and asserted outputs:
  - IDLE: all outputs 0. Go to T0 if run=1, else stay.
  - T0: PCout, MARin, IncPC, Zlowin. Go to T1.
  - T1: Zlowout, PCin (first cycle only), Read, MDRin.
    - Stay while mem_ready=0. Read and MDRin stay asserted on every wait cycle.
    - PCin is asserted only in the first T1 cycle, so PC+1 is not reloaded on wait cycles.
    - Go to T2 on a cycle with mem_ready=1.
  - T2: MDRout, IRin. Go to T3; the IR is valid from T3 on.
  - T3: decode op.
    - HALT opcode: go to HALT.
    - NOP or illegal opcode: go to T0 if run=1, else IDLE. Assert nothing.
    - Otherwise: assert Rout[rb] and Yin, then go to T4.
  - T4: Rout[rc], Zlowin.
    - ALU ops: ALUop from the package table.
    - mul/div: ALU_MUL or ALU_DIV, plus Zhighin; ALUop = 0.
    - Go to T5.
  - T5:
    - ALU ops: Zlowout, Rin[ra]; then go to T0 if run=1, else IDLE.
    - mul/div: Zlowout, LOin; go to T6.
  - T6: Zhighout, HIin; then go to T0 if run=1, else IDLE.
  - HALT: halted=1, all strobes 0. Exit only via clear.
- Latency:
  - ALU op: 6 cycles.
  - mul/div: 7 cycles.
  - Each mem_ready=0 cycle in T1 adds 1 cycle.
- run dropping mid-instruction does not abort; it is sampled only at instruction end.
- ra=0 is a legal write target; there is no R0 special-casing.
- Bus exclusivity: at most one *out strobe (Rout bit, PCout, MDRout, Zlowout, Zhighout) is high in any cycle. Verification checks this with an assertion.
- Opcode table:
  - add 00000, sub 00001, and 00010, or 00011;
  - shr 00100, shl 00101, ror 00110, rol 00111;
  - neg 01000, not 01001;
  - mul 01111, div 10000;
  - nop 11010, halt 11011;
  - all others illegal (treated as nop).
- ALUop codes: add 0, sub 1, and 2, or 3, shr 4, shl 5, ror 6, rol 7, neg 8, not 9.
- Unary ops (neg, not) still execute T3 with rb; rc is ignored by the ALU.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum (IDLE, T0–T6, HALT);
  - opcode localparams;
  - ALUop localparams;
  - the field bit positions.
- One sub-module, reg_onehot_dec: 4-to-16 decoder with an enable input, instantiated twice (once for Rin, once for Rout).

Test Plan:
- Reset and idle: clear=1, then run=0 for 5 cycles -> all outputs 0, busy=0.
- Divide: run=1, mem_ready=1, ir_q=0x81988000 (div ra=3 rb=3 rc=1) -> checks:
  - T3: Rout=0x0008 with Yin;
  - T4: Rout=0x0002 with ALU_DIV and Zhighin;
  - T5: LOin; T6: HIin;
  - the next T0 arrives 7 cycles after the first.
- Add with wait states: ir_q=0x02920000 (add R5,R2,R4), mem_ready low for 3 cycles in T1 -> checks:
  - PCin asserted exactly once;
  - Read held for 4 cycles;
  - T4: ALUop=0, Rout=0x0010;
  - T5: Rin=0x0020.
- Halt: ir_q=0xD8000000 -> checks:
  - HALT reached after T3, halted=1;
  - no strobes while run=1 for 10 cycles;
  - clear returns the sequencer to IDLE.
- Illegal opcode and async reset: ir_q=0xF8000000 -> T3 goes straight to T0 with no Rout/Yin. Then assert clear mid-T4 of an add -> outputs drop to 0 in the same cycle, before the next clock edge.
- Bus exclusivity: 500 random-opcode instructions with random mem_ready -> assertion never fires.
